// File: rtl/rv_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// rv_div_unit_pkg
//   Shared definitions for the RV32M iterative divide unit:
//     - default widths (XLEN_DEF, CNT_W_DEF)
//     - op encodings (funct3[1:0]): OP_DIV / OP_DIVU / OP_REM / OP_REMU
//     - FSM state encodings: S_IDLE / S_CALC / S_FIX
//     - small op-decode helpers
// ---------------------------------------------------------------------------
package rv_div_unit_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    // DIV and REM interpret operands as two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/rv_div_unit_udiv_iter.sv
// ---------------------------------------------------------------------------
// udiv_iter
//   Unsigned radix-2 restoring divider core. One quotient bit per clock.
//   Ports:
//     clk          in   clock, all state on posedge
//     rst_n        in   synchronous active-low reset
//     load_i       in   capture operands and start XLEN iterations
//     dividend_i   in   XLEN unsigned dividend magnitude
//     divisor_i    in   XLEN unsigned divisor magnitude (non-zero)
//     last_o       out  the step taken on the coming edge is the final one
//     quotient_o   out  XLEN quotient (valid once iterations finish)
//     remainder_o  out  XLEN remainder (valid once iterations finish)
// ---------------------------------------------------------------------------
module udiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            last_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;

    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    trial;
    logic [XLEN-1:0]  quo_d;
    logic [XLEN-1:0]  rem_d;

    // Partial remainder is always < divisor, so the shifted value needs
    // one extra bit; the trial subtraction's MSB is the borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        quo_d  = {quo_q[XLEN-2:0], 1'b0};
        rem_d  = rem_sh[XLEN-1:0];
        if (!trial[XLEN]) begin
            quo_d = {quo_q[XLEN-2:0], 1'b1};
            rem_d = trial[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
        end else if (load_i) begin
            active_q <= 1'b1;
            cnt_q    <= CNT_W'(XLEN - 1);
            quo_q    <= dividend_i;
            rem_q    <= '0;
            dvs_q    <= divisor_i;
        end else if (active_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end
        end
    end

    assign last_o      = active_q && (cnt_q == '0);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/rv_div_unit.sv
// ---------------------------------------------------------------------------
// rv_div_unit
//   Iterative RV32M divide unit (DIV/DIVU/REM/REMU). Wraps the unsigned
//   restoring core with op decode, magnitude/sign capture, the divide-by-zero
//   and signed-overflow bypass, and the final sign fix-up.
//   Ports:
//     clk       in   clock, all state on posedge
//     rst_n     in   synchronous active-low reset
//     start     in   request, only sampled in IDLE (and not in the done cycle)
//     op        in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//     dividend  in   XLEN rs1 value
//     divisor   in   XLEN rs2 value
//     busy      out  high from the accepting edge until the edge raising done
//     done      out  one-cycle pulse, result valid in the same cycle
//     result    out  XLEN quotient or remainder, held until next accepted start
// ---------------------------------------------------------------------------
module rv_div_unit
    import rv_div_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] result_d;
    logic            rem_sel_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            bypass_q;
    logic [XLEN-1:0] bypass_val_q;

    logic            sgn_op;
    logic            sgn_a;
    logic            sgn_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] bypass_val_d;
    logic            accept;
    logic            core_load;
    logic            core_last;
    logic [XLEN-1:0] core_quo;
    logic [XLEN-1:0] core_rem;

    // Operand conditioning at the accepting edge. The magnitude of INT_MIN
    // is 2**(XLEN-1), which is representable as an unsigned XLEN value.
    always_comb begin
        sgn_op   = op_is_signed(op);
        sgn_a    = sgn_op & dividend[XLEN-1];
        sgn_b    = sgn_op & divisor[XLEN-1];
        mag_a    = sgn_a ? (~dividend + XLEN'(1)) : dividend;
        mag_b    = sgn_b ? (~divisor + XLEN'(1)) : divisor;
        div_zero = (divisor == '0);
        ovf      = sgn_op && (dividend == INT_MIN) && (divisor == '1);
        special  = div_zero || ovf;
        // Bypassed results skip the sign fix-up entirely.
        if (op_is_rem(op)) begin
            bypass_val_d = div_zero ? dividend : '0;
        end else begin
            bypass_val_d = div_zero ? '1 : dividend;
        end
    end

    // done_q is high only while state_q is back in IDLE, so gating on it
    // makes a start held during the done cycle a no-op.
    assign accept    = (state_q == S_IDLE) && start && !done_q;
    assign core_load = accept && !special;

    udiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (core_load),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .last_o      (core_last),
        .quotient_o  (core_quo),
        .remainder_o (core_rem)
    );

    // Sign fix-up: quotient negative iff operand signs differ, remainder
    // follows the dividend. Negating zero gives zero, so no special case.
    always_comb begin
        if (bypass_q) begin
            result_d = bypass_val_q;
        end else if (rem_sel_q) begin
            result_d = neg_rem_q ? (~core_rem + XLEN'(1)) : core_rem;
        end else begin
            result_d = neg_quo_q ? (~core_quo + XLEN'(1)) : core_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            rem_sel_q    <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            bypass_q     <= 1'b0;
            bypass_val_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        busy_q       <= 1'b1;
                        rem_sel_q    <= op_is_rem(op);
                        neg_quo_q    <= sgn_a ^ sgn_b;
                        neg_rem_q    <= sgn_a;
                        bypass_q     <= special;
                        bypass_val_q <= bypass_val_d;
                        state_q      <= special ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (core_last) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_rv_div_unit.sv
// ---------------------------------------------------------------------------
// tb_rv_div_unit
//   Self-checking bench for rv_div_unit: table-driven vectors plus
//   hand-written sequences (restart while busy, reset mid-operation).
//   Expected results go into a queue at start and are checked on done.
// ---------------------------------------------------------------------------
module tb_rv_div_unit;
    import rv_div_unit_pkg::*;

    localparam int XLEN  = 32;
    localparam int LAT_N = XLEN + 1;
    localparam int LAT_S = 1;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [1:0]  op       = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor  = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    rv_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_done: got done with result 0x%08h, expected no done", result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", result, mon_exp);
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input int elat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        // Operands are scrambled after acceptance; they must not matter.
        start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom);
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k <= 100; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got no done in 100 cycles, expected done", name);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end else begin
            check({name, " latency"}, 32'(lat), 32'(elat));
            check({name, " busy_cycles"}, 32'(busy_cnt), 32'(elat));
            check({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
            $display("txn %-14s op=%0d a=0x%08h b=0x%08h -> result=0x%08h lat=%0d",
                     name, o, a, b, result, lat);
        end
        // A start raised in the done cycle must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " done_width"}, {31'd0, done}, 32'd0);
        check({name, " start_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t;

        vecs.push_back('{"divu_100_7",  OP_DIVU, 32'd100,        32'd7,          32'd14,         LAT_N});
        vecs.push_back('{"remu_100_7",  OP_REMU, 32'd100,        32'd7,          32'd2,          LAT_N});
        vecs.push_back('{"div_m20_3",   OP_DIV,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  LAT_N});
        vecs.push_back('{"rem_m20_3",   OP_REM,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  LAT_N});
        vecs.push_back('{"div_20_m3",   OP_DIV,  32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  LAT_N});
        vecs.push_back('{"rem_20_m3",   OP_REM,  32'd20,         32'hFFFF_FFFD,  32'd2,          LAT_N});
        vecs.push_back('{"div_m7_m2",   OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          LAT_N});
        vecs.push_back('{"rem_m7_m2",   OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  LAT_N});
        vecs.push_back('{"rem_m6_3",    OP_REM,  32'hFFFF_FFFA,  32'd3,          32'd0,          LAT_N});
        vecs.push_back('{"div_5_0",     OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  LAT_S});
        vecs.push_back('{"remu_5_0",    OP_REMU, 32'd5,          32'd0,          32'd5,          LAT_S});
        vecs.push_back('{"divu_3_0",    OP_DIVU, 32'd3,          32'd0,          32'hFFFF_FFFF,  LAT_S});
        vecs.push_back('{"rem_m5_0",    OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  LAT_S});
        vecs.push_back('{"div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LAT_S});
        vecs.push_back('{"rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_S});
        vecs.push_back('{"divu_min_2",  OP_DIVU, 32'h8000_0000,  32'd2,          32'h4000_0000,  LAT_N});
        vecs.push_back('{"divu_min_m1", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_N});
        vecs.push_back('{"div_min_1",   OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  LAT_N});
        vecs.push_back('{"rem_min_3",   OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  LAT_N});
        vecs.push_back('{"divu_max_1",  OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LAT_N});
        vecs.push_back('{"remu_max_10", OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          LAT_N});

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Restart attempt while busy: ignored, first result returned once.
        @(negedge clk);
        op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        exp_q.push_back(32'd14);
        @(negedge clk);
        start = 1'b0;
        t = 0;
        repeat (4) begin
            @(negedge clk);
            t++;
        end
        op = OP_DIV; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        t++;
        start = 1'b0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("restart_busy latency", 32'(t), 32'(LAT_N));
        $display("txn restart_busy   op=1 a=0x00000064 b=0x00000007 -> result=0x%08h lat=%0d", result, t);
        repeat (40) @(negedge clk);

        // Reset mid-calculation: operation discarded, no done.
        op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        exp_q.push_back(32'd14);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        $display("txn mid_reset      op=1 a=0x00000064 b=0x00000007 -> aborted");
        repeat (40) @(negedge clk);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_N);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
